alu_uart_sequencer: RTL

Frame sequencer between the UART receiver/transmitter and the combinational ALU. It collects three received bytes in order (operand A, operand B, opcode) and drives them onto the ALU inputs. It then captures the ALU result and transmits it back through the UART transmitter with a start/done handshake. Replaces ad-hoc capture logic at the top level and adds overrun and inter-byte timeout handling.

---
 rtl/alu_uart_sequencer_if.sv | 50 +++++
 rtl/alu_uart_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_sequencer_if.sv
// Bus bundle between the frame sequencer and its surroundings:
// UART receiver, combinational ALU, UART transmitter and status pulses.
// The master modport is the sequencer's view; slave is the environment's.
interface alu_uart_sequencer_if #(
    parameter int NB_DATA = 8,
    parameter int NB_CODE = 6
) ();
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_rx_data;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_CODE-1:0] o_alu_op;
    logic [NB_DATA-1:0] i_alu_result;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               i_tx_done;
    logic               o_busy;
    logic               o_overrun;
    logic               o_frame_err;

    modport master (
        input  i_rx_done,
        input  i_rx_data,
        input  i_alu_result,
        input  i_tx_done,
        output o_alu_a,
        output o_alu_b,
        output o_alu_op,
        output o_tx_start,
        output o_tx_data,
        output o_busy,
        output o_overrun,
        output o_frame_err
    );

    modport slave (
        output i_rx_done,
        output i_rx_data,
        output i_alu_result,
        output i_tx_done,
        input  o_alu_a,
        input  o_alu_b,
        input  o_alu_op,
        input  o_tx_start,
        input  o_tx_data,
        input  o_busy,
        input  o_overrun,
        input  o_frame_err
    );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Frame sequencer: collects operand A, operand B and opcode bytes from the
// UART receiver, presents them to the ALU, captures the result and sends it
// back through the UART transmitter with a start/done handshake.
// Optional inter-byte timeout is enabled by defining SEQ_TIMEOUT_EN; without
// it no timeout counter exists and o_frame_err stays 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// GET_A   | idle, waiting for operand A byte
// GET_B   | waiting for operand B byte (timeout counting when enabled)
// GET_OP  | waiting for opcode byte (timeout counting when enabled)
// EXEC    | one cycle, ALU result captured into the tx register
// SEND    | one cycle, o_tx_start high
// WAIT_TX | waiting for transmitter done pulse
module alu_uart_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_CODE        = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic                  i_clk,
    input logic                  i_reset,
    alu_uart_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic               ld_a;
    logic               ld_b;
    logic               ld_op;
    logic               ld_res;
    logic               clr_data;
    logic               clr_res;
    logic               overrun_next;
    logic               tmr_expired;

    logic [NB_DATA-1:0] alu_a_q;
    logic [NB_DATA-1:0] alu_b_q;
    logic [NB_CODE-1:0] alu_op_q;
    logic [NB_DATA-1:0] tx_data_q;
    logic               tx_start_q;
    logic               busy_q;
    logic               overrun_q;

    // State register; reset lands in GET_A immediately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath load/clear strobes.
    always_comb begin
        state_next   = state;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        ld_op        = 1'b0;
        ld_res       = 1'b0;
        clr_data     = 1'b0;
        clr_res      = 1'b0;
        overrun_next = 1'b0;
        case (state)
            GET_A: begin
                if (bus.i_rx_done) begin
                    ld_a       = 1'b1;
                    state_next = GET_B;
                end
            end
            GET_B: begin
                // A byte arriving on the expiry cycle still wins.
                if (bus.i_rx_done) begin
                    ld_b       = 1'b1;
                    state_next = GET_OP;
                end else if (tmr_expired) begin
                    clr_data   = 1'b1;
                    state_next = GET_A;
                end
            end
            GET_OP: begin
                if (bus.i_rx_done) begin
                    ld_op      = 1'b1;
                    state_next = EXEC;
                end else if (tmr_expired) begin
                    clr_data   = 1'b1;
                    state_next = GET_A;
                end
            end
            EXEC: begin
                ld_res       = 1'b1;
                overrun_next = bus.i_rx_done;
                state_next   = SEND;
            end
            SEND: begin
                overrun_next = bus.i_rx_done;
                state_next   = WAIT_TX;
            end
            WAIT_TX: begin
                overrun_next = bus.i_rx_done;
                if (bus.i_tx_done) begin
                    state_next = GET_A;
                end
            end
            default: begin
                clr_data   = 1'b1;
                clr_res    = 1'b1;
                state_next = GET_A;
            end
        endcase
    end

    // Operand, opcode and result registers plus registered status outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (clr_data) begin
                alu_a_q  <= '0;
                alu_b_q  <= '0;
                alu_op_q <= '0;
            end else begin
                if (ld_a) begin
                    alu_a_q <= bus.i_rx_data;
                end
                if (ld_b) begin
                    alu_b_q <= bus.i_rx_data;
                end
                if (ld_op) begin
                    alu_op_q <= bus.i_rx_data[NB_CODE-1:0];
                end
            end
            if (clr_res) begin
                tx_data_q <= '0;
            end else if (ld_res) begin
                tx_data_q <= bus.i_alu_result;
            end
            tx_start_q <= (state_next == SEND);
            busy_q     <= (state_next == EXEC) || (state_next == SEND) ||
                          (state_next == WAIT_TX);
            overrun_q  <= overrun_next;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int NB_TMR = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NB_TMR-1:0] TMR_LAST = NB_TMR'(TIMEOUT_CYCLES - 1);

    logic [NB_TMR-1:0] tmr_q;
    logic              tmr_run;
    logic              frame_err_q;

    assign tmr_run     = (state == GET_B) || (state == GET_OP);
    assign tmr_expired = tmr_run && (tmr_q == TMR_LAST);

    // Inter-byte timer: runs only mid-frame, restarts on every accepted byte.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tmr_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            if (!tmr_run || bus.i_rx_done || tmr_expired) begin
                tmr_q <= '0;
            end else begin
                tmr_q <= tmr_q + NB_TMR'(1);
            end
            frame_err_q <= tmr_expired && !bus.i_rx_done;
        end
    end

    assign bus.o_frame_err = frame_err_q;
`else
    assign tmr_expired     = 1'b0;
    assign bus.o_frame_err = 1'b0;
`endif

    assign bus.o_alu_a    = alu_a_q;
    assign bus.o_alu_b    = alu_b_q;
    assign bus.o_alu_op   = alu_op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_overrun  = overrun_q;

endmodule
